flit_inject_mux: RTL and testbench
==================================

Name: flit_inject_mux

Overview:
- N-channel, credit-based flit stream concentrator for the simulation/injection path.
- Merges packets from several task-injector sources onto one credit-based NoC input port, so that management and application injection can share a single PE port.
- Each source has its own FIFO. Packets are forwarded atomically under round-robin arbitration.
- Packet framing: flit 0 is the header, flit 1 is the payload size, followed by that many payload flits.

Parameters:
- N_CH, 2, number of source channels (at least 2).
- FLIT_SIZE, 32, flit width in bits.
- BUF_DEPTH, 4, per-channel FIFO depth in flits (power of two, at least 2).
- SIZE_W, 16, low bits of flit 1 interpreted as the unsigned payload flit count.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- src_rx_i  in  N_CH  per-channel flit valid.
- src_data_i  in  N_CH*FLIT_SIZE  per-channel flit; channel i occupies bits [i*FLIT_SIZE +: FLIT_SIZE].
- src_credit_o  out  N_CH  per-channel "can accept"; high when that FIFO is not full.
- tx_o  out  1  output flit valid.
- data_o  out  FLIT_SIZE  output flit.
- credit_i  in  1  downstream can accept.
- grant_o  out  $clog2(N_CH)  channel currently owning the output; valid when busy_o is high.
- busy_o  out  1  a packet is in progress (state is not IDLE).

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values:
  - all FIFOs empty; src_credit_o all ones;
  - tx_o=0, data_o=0, busy_o=0, grant_o=0;
  - round-robin pointer=N_CH-1, so channel 0 has first priority;
  - state=IDLE.
- Reset asserted mid-packet: aborts the packet and flushes all FIFOs. No partial packet resumes after reset.
- Input side:
  - a write to FIFO i happens when src_rx_i[i] && src_credit_o[i];
  - src_credit_o[i] = !full_i, evaluated combinationally on FIFO occupancy;
  - a read and a write on the same FIFO in the same cycle are both allowed; occupancy is unchanged;
  - a write into a full FIFO cannot occur, because credit is low. src_rx_i while credit is low is ignored.
- Transfer rule: a flit transfers on the output when tx_o && credit_i.
  - tx_o = (state is not IDLE) && !empty[grant];
  - data_o = head of FIFO[grant] while tx_o is high, otherwise 0.
- FSM:
  - IDLE: search channels starting at pointer+1 (mod N_CH) for the first non-empty FIFO. If one is found: grant=it, pointer=it, state=HDR. Arbitration costs exactly one cycle. No flit is sent in IDLE.
  - HDR: on transfer, go to SIZE.
  - SIZE: on transfer, latch cnt = data_o[SIZE_W-1:0]. If cnt==0 go to IDLE, else go to PAYLOAD.
  - PAYLOAD: on each transfer, decrement cnt. On the transfer where cnt==1, go to IDLE.
- Atomicity: grant never changes between HDR and the last payload flit, even when another FIFO is full. An empty granted FIFO mid-packet stalls the output (tx_o=0) and holds state.
- Fairness: after a packet from channel k completes, channel k has lowest priority at the next arbitration.
- Latency: a flit written into an empty FIFO of the granted channel in cycle t is visible on tx_o/data_o in cycle t+1.
  - Minimum gap between two back-to-back packets: one idle cycle (the IDLE arbitration cycle).
- Width rules:
  - cnt is SIZE_W bits; flit-1 bits above SIZE_W are forwarded unchanged but ignored for counting;
  - the maximum payload is 2^SIZE_W-1 flits;
  - the FIFO pointers wrap modulo BUF_DEPTH, with one extra bit per pointer for full/empty disambiguation.
- Backpressure: credit_i low freezes the FIFO heads, cnt and state. tx_o and data_o stay stable until the transfer.

Test Plan:
- Single packet, channel 0:
  - Stimulus: inject header 0x00000102, size 0x00000003, payloads 0xA1, 0xA2, 0xA3, with credit_i=1.
  - Required: data_o sequence 0x102, 0x3, 0xA1, 0xA2, 0xA3 on 5 consecutive tx cycles. busy_o drops 1 cycle after the last flit. grant_o=0.
- Zero-size packet:
  - Stimulus: header 0x55, size 0x0.
  - Required: exactly 2 output flits, then IDLE. The next queued packet's header appears 1 cycle later.
- Round-robin, N_CH=2:
  - Stimulus: both channels preloaded with 2 packets of size 1 each.
  - Required: output order ch0, ch1, ch0, ch1. Flits never interleave within a packet.
- Backpressure:
  - Stimulus: credit_i=0 for 10 cycles mid-payload.
  - Required: tx_o=1 and data_o are held constant. The source FIFO fills to 4 and src_credit_o drops to 0. On credit_i=1, all flits are delivered in order with none lost or duplicated.
- Stall on empty:
  - Stimulus: channel 1 granted; its source pauses after header and size. Channel 0 has a full FIFO.
  - Required: tx_o=0 and grant_o stays 1 until channel 1 resumes. Channel 0 is served only after channel 1's last flit.
- Reset mid-packet:
  - Stimulus: assert rst_ni low asynchronously during PAYLOAD.
  - Required: outputs go to reset values immediately and all FIFOs are empty. After release, a fresh packet on channel 0 transfers correctly.

Source files
------------

// File: rtl/flit_inject_mux.sv
// flit_inject_mux: N-channel credit-based flit concentrator with per-channel FIFOs and
// atomic round-robin packet forwarding onto one NoC input port. Rev 1.0
`default_nettype none

module flit_inject_mux #(
  parameter int N_CH      = 2,
  parameter int FLIT_SIZE = 32,
  parameter int BUF_DEPTH = 4,
  parameter int SIZE_W    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_CH-1:0]           src_rx_i,
  input  logic [N_CH*FLIT_SIZE-1:0] src_data_i,
  output logic [N_CH-1:0]           src_credit_o,
  output logic                      tx_o,
  output logic [FLIT_SIZE-1:0]      data_o,
  input  logic                      credit_i,
  output logic [$clog2(N_CH)-1:0]   grant_o,
  output logic                      busy_o
);

  localparam int GW = $clog2(N_CH);
  localparam int AW = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_SIZE    = 2'd2,
    S_PAYLOAD = 2'd3
  } state_t;

  state_t                           r_state;
  logic [GW-1:0]                    r_grant;
  logic [GW-1:0]                    r_ptr;
  logic [SIZE_W-1:0]                r_cnt;

  logic [N_CH-1:0]                  w_empty;
  logic [N_CH-1:0]                  w_full;
  logic [N_CH-1:0]                  w_push;
  logic [N_CH-1:0]                  w_pop;
  logic [N_CH-1:0][FLIT_SIZE-1:0]   w_head;
  logic [FLIT_SIZE-1:0]             w_head_g;
  logic                             w_tx;
  logic                             w_xfer;
  logic                             w_found;
  logic [GW-1:0]                    w_pick;

  for (genvar g = 0; g < N_CH; g++) begin : g_fifo
    logic [FLIT_SIZE-1:0] r_mem [BUF_DEPTH];
    logic [AW:0]          r_wptr;
    logic [AW:0]          r_rptr;

    // Extra MSB on each pointer separates the full and empty cases.
    assign w_empty[g] = (r_wptr == r_rptr);
    assign w_full[g]  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push[g]  = src_rx_i[g] && !w_full[g];
    assign w_pop[g]   = w_xfer && (r_grant == GW'(g));
    assign w_head[g]  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push[g]) r_wptr <= r_wptr + (AW+1)'(1);
        if (w_pop[g])  r_rptr <= r_rptr + (AW+1)'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (w_push[g]) r_mem[r_wptr[AW-1:0]] <= src_data_i[g*FLIT_SIZE +: FLIT_SIZE];
    end
  end

  assign src_credit_o = ~w_full;

  assign w_head_g = w_head[r_grant];
  assign w_tx     = (r_state != S_IDLE) && !w_empty[r_grant];
  assign w_xfer   = w_tx && credit_i;

  assign tx_o    = w_tx;
  assign data_o  = w_tx ? w_head_g : '0;
  assign grant_o = r_grant;
  assign busy_o  = (r_state != S_IDLE);

  // Scan from highest to lowest index so the last hit is the one nearest pointer+1.
  always_comb begin
    int v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = N_CH; k >= 1; k--) begin
      v_idx = (int'(r_ptr) + k) % N_CH;
      if (!w_empty[v_idx[GW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = v_idx[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= GW'(N_CH - 1);
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_ptr   <= w_pick;
            r_state <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_xfer) r_state <= S_SIZE;
        end
        S_SIZE: begin
          if (w_xfer) begin
            r_cnt   <= w_head_g[SIZE_W-1:0];
            r_state <= (w_head_g[SIZE_W-1:0] == '0) ? S_IDLE : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (w_xfer) begin
            r_cnt <= r_cnt - SIZE_W'(1);
            if (r_cnt == SIZE_W'(1)) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flit_inject_mux.sv
// tb_flit_inject_mux: directed stimulus with a packet-level reference model checked every cycle.
`default_nettype none

module tb_flit_inject_mux;

  localparam int N_CH  = 2;
  localparam int FS    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               tb_rx  [N_CH];
  logic [FS-1:0]      tb_dat [N_CH];
  logic [N_CH-1:0]    src_rx;
  logic [N_CH*FS-1:0] src_data;
  logic [N_CH-1:0]    src_credit;
  logic               tx;
  logic [FS-1:0]      data;
  logic               credit_in;
  logic [0:0]         grant;
  logic               busy;

  always_comb begin
    src_rx   = '0;
    src_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      src_rx[i]           = tb_rx[i];
      src_data[i*FS +: FS] = tb_dat[i];
    end
  end

  flit_inject_mux #(.N_CH(N_CH), .FLIT_SIZE(FS), .BUF_DEPTH(DEPTH), .SIZE_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .src_rx_i(src_rx), .src_data_i(src_data),
    .src_credit_o(src_credit), .tx_o(tx), .data_o(data), .credit_i(credit_in),
    .grant_o(grant), .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: per-channel flit queues plus packet ownership.
  logic [FS-1:0] mq   [N_CH][$];
  logic [FS-1:0] srcq [N_CH][$];
  bit            acc  [N_CH];
  int            m_owner = -1;
  int            m_last  = N_CH - 1;
  int            m_sent  = 0;
  int            m_total = -1;

  logic [FS-1:0] lg_d [$];
  int            lg_ch [$];
  int            lg_cyc [$];
  logic [FS-1:0] expq [$];
  int            busy_fall = -1;
  bit            prev_busy = 1'b0;

  bit            e_tx;
  logic [FS-1:0] e_data;
  bit            e_busy;
  logic [N_CH-1:0] e_cred;
  logic [FS-1:0] popped;

  task automatic chk(input string nm, input logic [FS-1:0] act, input logic [FS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        for (int i = 0; i < N_CH; i++) begin
          mq[i].delete();
          acc[i] = 1'b0;
        end
        m_owner = -1; m_last = N_CH - 1; m_sent = 0; m_total = -1;
        prev_busy = 1'b0;
      end else begin
        e_busy = (m_owner >= 0);
        e_tx   = e_busy && (mq[m_owner].size() > 0);
        e_data = e_tx ? mq[m_owner][0] : '0;
        for (int i = 0; i < N_CH; i++) e_cred[i] = (mq[i].size() < DEPTH);
        chk("tx_o", tx, e_tx);
        chk("data_o", data, e_data);
        chk("busy_o", busy, e_busy);
        chk("src_credit_o", src_credit, e_cred);
        if (e_busy) chk("grant_o", grant, m_owner);

        if (tx && credit_in) begin
          lg_d.push_back(data);
          lg_ch.push_back(int'(grant));
          lg_cyc.push_back(cyc);
        end
        if (prev_busy && !busy) busy_fall = cyc;
        prev_busy = busy;

        for (int i = 0; i < N_CH; i++) acc[i] = tb_rx[i] && e_cred[i];
        if (m_owner < 0) begin
          for (int k = 1; k <= N_CH; k++) begin
            if (m_owner < 0 && mq[(m_last + k) % N_CH].size() > 0) begin
              m_owner = (m_last + k) % N_CH;
              m_last  = m_owner;
              m_sent  = 0;
              m_total = -1;
            end
          end
        end else if (e_tx && credit_in) begin
          popped = mq[m_owner].pop_front();
          m_sent++;
          if (m_sent == 2) m_total = 2 + int'(popped[15:0]);
          if (m_total >= 0 && m_sent == m_total) m_owner = -1;
        end
        for (int i = 0; i < N_CH; i++) if (acc[i]) mq[i].push_back(tb_dat[i]);
      end
    end
  end

  task automatic feed(input int c);
    forever begin
      @(posedge clk);
      #1;
      if (tb_rx[c] && acc[c] && srcq[c].size() > 0) void'(srcq[c].pop_front());
      if (srcq[c].size() > 0) begin
        tb_rx[c]  = 1'b1;
        tb_dat[c] = srcq[c][0];
      end else begin
        tb_rx[c]  = 1'b0;
        tb_dat[c] = '0;
      end
    end
  endtask

  for (genvar g = 0; g < N_CH; g++) begin : g_feed
    initial feed(g);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_idle();
    bit r;
    r = (m_owner < 0);
    for (int i = 0; i < N_CH; i++)
      if (srcq[i].size() > 0 || mq[i].size() > 0 || tb_rx[i]) r = 1'b0;
    return r;
  endfunction

  task automatic wait_done(input string nm, input int budget);
    for (int n = 0; n < budget; n++) begin
      tick();
      if (model_idle()) begin
        repeat (3) tick();
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s timeout actual=busy required=idle", nm);
  endtask

  task automatic wait_log(input string nm, input int cnt, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (lg_d.size() >= cnt) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL %s timeout actual=%0d flits required=%0d", nm, lg_d.size(), cnt);
  endtask

  task automatic clear_log();
    lg_d.delete();
    lg_ch.delete();
    lg_cyc.delete();
  endtask

  task automatic chk_seq(input string nm);
    chk({nm, "_len"}, lg_d.size(), expq.size());
    for (int i = 0; i < expq.size() && i < lg_d.size(); i++) chk(nm, lg_d[i], expq[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      srcq[i].delete();
      tb_rx[i]  = 1'b0;
      tb_dat[i] = '0;
    end
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [FS-1:0] held;

  initial begin
    for (int i = 0; i < N_CH; i++) begin
      tb_rx[i]  = 1'b0;
      tb_dat[i] = '0;
    end
    credit_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_tx", tx, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_credit", src_credit, 2'b11);
    rst_n = 1'b1;
    tick();

    // Single packet on channel 0
    clear_log();
    srcq[0] = '{32'h102, 32'h3, 32'hA1, 32'hA2, 32'hA3};
    wait_done("t1", 100);
    expq = '{32'h102, 32'h3, 32'hA1, 32'hA2, 32'hA3};
    chk_seq("t1_seq");
    if (lg_cyc.size() == 5) begin
      chk("t1_back2back", lg_cyc[4] - lg_cyc[0], 4);
      chk("t1_busy_drop", busy_fall, lg_cyc[4] + 1);
    end
    for (int i = 0; i < lg_ch.size(); i++) chk("t1_grant", lg_ch[i], 0);

    // Zero-size packet followed by another packet
    clear_log();
    srcq[0] = '{32'h55, 32'h0, 32'h77, 32'h1, 32'hB1};
    wait_done("t2", 100);
    expq = '{32'h55, 32'h0, 32'h77, 32'h1, 32'hB1};
    chk_seq("t2_seq");
    if (lg_cyc.size() == 5) chk("t2_gap", lg_cyc[2] - lg_cyc[1], 2);

    // Round-robin between two loaded channels
    do_reset();
    clear_log();
    srcq[0] = '{32'h10, 32'h1, 32'h11, 32'h12, 32'h1, 32'h13};
    srcq[1] = '{32'h20, 32'h1, 32'h21, 32'h22, 32'h1, 32'h23};
    wait_done("t3", 200);
    expq = '{32'h10, 32'h1, 32'h11, 32'h20, 32'h1, 32'h21,
             32'h12, 32'h1, 32'h13, 32'h22, 32'h1, 32'h23};
    chk_seq("t3_seq");
    for (int i = 0; i < 12 && i < lg_ch.size(); i++) chk("t3_order", lg_ch[i], (i / 3) % 2);

    // Backpressure mid-payload
    clear_log();
    srcq[0] = '{32'h40, 32'h6, 32'h41, 32'h42, 32'h43, 32'h44, 32'h45, 32'h46};
    wait_log("t4_start", 3, 100);
    credit_in = 1'b0;
    tick();
    held = data;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_tx", tx, 1);
      chk("t4_hold_data", data, held);
    end
    chk("t4_fifo_full", src_credit[0], 0);
    credit_in = 1'b1;
    wait_done("t4", 200);
    expq = '{32'h40, 32'h6, 32'h41, 32'h42, 32'h43, 32'h44, 32'h45, 32'h46};
    chk_seq("t4_seq");

    // Granted channel 1 runs dry while channel 0 waits full
    clear_log();
    srcq[1] = '{32'h60, 32'h2};
    wait_log("t5_start", 2, 100);
    srcq[0] = '{32'h70, 32'h2, 32'h71, 32'h72};
    repeat (8) tick();
    chk("t5_stall_tx", tx, 0);
    chk("t5_stall_grant", grant, 1);
    chk("t5_stall_busy", busy, 1);
    chk("t5_ch0_full", src_credit[0], 0);
    chk("t5_no_flits", lg_d.size(), 2);
    srcq[1].push_back(32'h61);
    srcq[1].push_back(32'h62);
    wait_done("t5", 200);
    expq = '{32'h60, 32'h2, 32'h61, 32'h62, 32'h70, 32'h2, 32'h71, 32'h72};
    chk_seq("t5_seq");

    // Asynchronous reset mid-payload
    clear_log();
    srcq[0] = '{32'h80, 32'h5, 32'h81, 32'h82, 32'h83, 32'h84, 32'h85};
    wait_log("t6_start", 3, 100);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      srcq[i].delete();
      tb_rx[i]  = 1'b0;
      tb_dat[i] = '0;
    end
    #1;
    chk("t6_rst_tx", tx, 0);
    chk("t6_rst_data", data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_credit", src_credit, 2'b11);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_log();
    srcq[0] = '{32'h90, 32'h1, 32'h91};
    wait_done("t6", 100);
    expq = '{32'h90, 32'h1, 32'h91};
    chk_seq("t6_seq");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
